// File: rtl/leb128_pkg.sv
// Shared constants for the LEB128 immediate reader: trap codes (cpu numbering),
// FSM state encoding and per-width byte limits.
package leb128_pkg;

    localparam logic [3:0] TRAP_NONE     = 4'd0;
    localparam logic [3:0] TRAP_MEM      = 4'd1;
    localparam logic [3:0] TRAP_OVERLONG = 4'd2;
    localparam logic [3:0] TRAP_BITS     = 4'd3;

    localparam logic [3:0] L32 = 4'd5;
    localparam logic [3:0] L64 = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM
    } state_e;

    // Index of the last byte an encoding may occupy for the selected width.
    function automatic logic [3:0] last_index(input logic is64);
        return is64 ? (L64 - 4'd1) : (L32 - 4'd1);
    endfunction

endpackage

// File: rtl/leb128_accum.sv
// Combinational per-byte step: merges one 7-bit group into the accumulator,
// produces the width-extended result and validates the unused bits of a final byte.
module leb128_accum
    import leb128_pkg::*;
(
    input  logic [63:0] acc_i,
    input  logic [7:0]  data_i,
    input  logic [3:0]  idx_i,
    input  logic        is_signed_i,
    input  logic        is64_i,
    output logic [63:0] acc_o,
    output logic [63:0] value_o,
    output logic        last_o,
    output logic        bits_ok_o
);

    logic [6:0]  shamt;
    logic [6:0]  pos_raw;
    logic [6:0]  msb;
    logic [6:0]  pos;
    logic [63:0] mask;
    logic        sign;

    assign shamt   = 7'(idx_i) * 7'd7;
    assign acc_o   = acc_i | ({57'd0, data_i[6:0]} << shamt);

    // Sign position is the top decoded bit, clamped to the operand MSB; a shift by 64
    // yields zero so the mask correctly becomes all ones for a full 64-bit operand.
    assign pos_raw = shamt + 7'd6;
    assign msb     = is64_i ? 7'd63 : 7'd31;
    assign pos     = (pos_raw > msb) ? msb : pos_raw;
    assign mask    = (64'd1 << (pos + 7'd1)) - 64'd1;
    assign sign    = acc_o[pos[5:0]];
    assign value_o = (is_signed_i && sign) ? (acc_o | ~mask) : (acc_o & mask);

    assign last_o  = (idx_i == last_index(is64_i));

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        bits_ok_o = 1'b1;
        if (last_o) begin
            unique case ({is64_i, is_signed_i})
                2'b00:   bits_ok_o = (data_i[6:4] == 3'b000);
                2'b01:   bits_ok_o = (data_i[6:3] == 4'h0) || (data_i[6:3] == 4'hF);
                2'b10:   bits_ok_o = (data_i[6:1] == 6'd0);
                default: bits_ok_o = (data_i[6:0] == 7'h00) || (data_i[6:0] == 7'h7F);
            endcase
        end
    end

endmodule

// File: rtl/leb128_reader.sv
// Streaming LEB128 immediate reader: fetches one byte per cycle from a synchronous
// byte ROM and returns the decoded operand, its length and the following address.
module leb128_reader
    import leb128_pkg::*;
#(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [MEM_ADDR:0]          addr_in,
    input  logic                       is_signed,
    input  logic                       is64,
    output logic                       busy,
    output logic                       done,
    output logic [63:0]                value,
    output logic [3:0]                 length,
    output logic [MEM_ADDR:0]          next_addr,
    output logic [3:0]                 trap,
    output logic [MEM_ADDR:0]          mem_addr,
    output logic [MEM_EXTRA-1:0]       mem_extra,
    input  logic [2**MEM_EXTRA*8-1:0]  mem_data,
    input  logic                       mem_error
);

    localparam int AW = MEM_ADDR + 1;

    state_e          state_q;
    logic [63:0]     acc_q;
    logic [3:0]      idx_q;
    logic            signed_q;
    logic            is64_q;
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   mem_addr_q;
    logic            busy_q;
    logic            done_q;
    logic [3:0]      trap_q;
    logic [63:0]     value_q;
    logic [3:0]      length_q;
    logic [AW-1:0]   next_addr_q;

    logic [63:0]     acc_d;
    logic [63:0]     value_d;
    logic            last;
    logic            bits_ok;
    logic [3:0]      fault_code;
    logic [7:0]      cur_byte;

    // Only the low byte lane carries data; the rest of the bus is deliberately ignored.
    logic            unused_mem_bits;
    assign unused_mem_bits = ^mem_data;

    assign cur_byte = mem_data[7:0];

    leb128_accum u_accum (
        .acc_i       (acc_q),
        .data_i      (cur_byte),
        .idx_i       (idx_q),
        .is_signed_i (signed_q),
        .is64_i      (is64_q),
        .acc_o       (acc_d),
        .value_o     (value_d),
        .last_o      (last),
        .bits_ok_o   (bits_ok)
    );

    always_comb begin
        fault_code = TRAP_NONE;
        if (mem_error)
            fault_code = TRAP_MEM;
        else if (cur_byte[7] && last)
            fault_code = TRAP_OVERLONG;
        else if (!cur_byte[7] && last && !bits_ok)
            fault_code = TRAP_BITS;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            signed_q    <= 1'b0;
            is64_q      <= 1'b0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            trap_q      <= TRAP_NONE;
            value_q     <= '0;
            length_q    <= '0;
            next_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        signed_q   <= is_signed;
                        is64_q     <= is64;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        trap_q     <= TRAP_NONE;
                        base_q     <= addr_in;
                        mem_addr_q <= addr_in;
                        busy_q     <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    mem_addr_q <= mem_addr_q + AW'(1);
                    state_q    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (fault_code != TRAP_NONE) begin
                        trap_q  <= fault_code;
                        value_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!cur_byte[7]) begin
                        value_q     <= value_d;
                        length_q    <= idx_q + 4'd1;
                        next_addr_q <= base_q + AW'(idx_q) + AW'(1);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 4'd1;
                        // mem_addr already points at byte idx+1; stop at the limit byte.
                        if ((idx_q + 4'd1) < last_index(is64_q))
                            mem_addr_q <= mem_addr_q + AW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign value     = value_q;
    assign length    = length_q;
    assign next_addr = next_addr_q;
    assign trap      = trap_q;
    assign mem_addr  = mem_addr_q;
    assign mem_extra = '0;

endmodule

// File: tb/tb_leb128_reader.sv
// Directed bench for leb128_reader: a small synchronous byte ROM with an upper
// bound, hand-computed decode results, latencies, traps and a mid-decode reset.
module tb_leb128_reader;

    localparam int AW = 5;
    localparam int DW = 128;
    localparam logic [4:0] UB = 5'd27;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   addr_in = '0;
    logic            is_signed = 1'b0;
    logic            is64 = 1'b0;
    logic            busy;
    logic            done;
    logic [63:0]     value;
    logic [3:0]      length;
    logic [AW-1:0]   next_addr;
    logic [3:0]      trap;
    logic [AW-1:0]   mem_addr;
    logic [3:0]      mem_extra;
    logic [DW-1:0]   mem_data;
    logic            mem_error;

    logic [7:0]      rom [32];

    int              checks = 0;
    int              failures = 0;
    logic            r_done;
    logic [3:0]      r_trap;
    int              r_lat;

    leb128_reader #(.MEM_ADDR(4), .MEM_EXTRA(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr_in   (addr_in),
        .is_signed (is_signed),
        .is64      (is64),
        .busy      (busy),
        .done      (done),
        .value     (value),
        .length    (length),
        .next_addr (next_addr),
        .trap      (trap),
        .mem_addr  (mem_addr),
        .mem_extra (mem_extra),
        .mem_data  (mem_data),
        .mem_error (mem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data  <= {120'd0, rom[mem_addr]};
        mem_error <= (mem_addr > UB);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts a decode at a negedge and returns at the negedge where done or trap is seen.
    task automatic run(input logic [4:0] a, input logic s, input logic w, input bit poke);
        int c;
        bit fin;
        addr_in   = a;
        is_signed = s;
        is64      = w;
        start     = 1'b1;
        c         = 0;
        fin       = 1'b0;
        r_done    = 1'b0;
        r_trap    = 4'd0;
        r_lat     = -1;
        while (!fin && c < 20) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                check("busy_after_start", 64'(busy), 64'd1);
                check("mem_addr_after_start", 64'(mem_addr), 64'(a));
            end
            if (poke && c == 2) begin
                start   = 1'b1;
                addr_in = 5'd0;
            end
            if (done || trap != 4'd0) begin
                fin    = 1'b1;
                r_done = done;
                r_trap = trap;
                r_lat  = c - 1;
            end
        end
        start = 1'b0;
        if (!fin) check("decode_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[1]  = 8'hE5; rom[2]  = 8'h8E; rom[3]  = 8'h26;
        rom[4]  = 8'hC0; rom[5]  = 8'hBB; rom[6]  = 8'h78;
        rom[7]  = 8'h7F;
        for (int i = 8; i < 13; i++) rom[i] = 8'h80;
        rom[13] = 8'h00;
        for (int i = 14; i < 18; i++) rom[i] = 8'hFF;
        rom[18] = 8'h1F;
        for (int i = 19; i < 23; i++) rom[i] = 8'hFF;
        rom[23] = 8'h0F;
        rom[24] = 8'h96; rom[25] = 8'h01;
        rom[27] = 8'h80; rom[28] = 8'h01;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_value", value, 64'd0);
        check("rst_length", 64'(length), 64'd0);
        check("rst_next_addr", 64'(next_addr), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_extra", 64'(mem_extra), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // 0x00 unsigned 32
        run(5'd0, 1'b0, 1'b0, 1'b0);
        check("t1_done", 64'(r_done), 64'd1);
        check("t1_trap", 64'(r_trap), 64'd0);
        check("t1_value", value, 64'd0);
        check("t1_length", 64'(length), 64'd1);
        check("t1_next", 64'(next_addr), 64'd1);
        check("t1_latency", 64'(r_lat), 64'd2);
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // 624485 with a start pulse while busy that must be ignored
        run(5'd1, 1'b0, 1'b0, 1'b1);
        check("t2_done", 64'(r_done), 64'd1);
        check("t2_value", value, 64'd624485);
        check("t2_length", 64'(length), 64'd3);
        check("t2_next", 64'(next_addr), 64'd4);
        check("t2_latency", 64'(r_lat), 64'd4);
        check("t2_mem_addr_frozen", 64'(mem_addr), 64'd4);

        // -123456 signed 64, started back-to-back in the done cycle
        run(5'd4, 1'b1, 1'b1, 1'b0);
        check("t3_done", 64'(r_done), 64'd1);
        check("t3_value", value, 64'hFFFF_FFFF_FFFE_1DC0);
        check("t3_length", 64'(length), 64'd3);
        check("t3_next", 64'(next_addr), 64'd7);
        check("t3_latency", 64'(r_lat), 64'd4);

        // 0x7F signed 32 -> -1
        run(5'd7, 1'b1, 1'b0, 1'b0);
        check("t4_done", 64'(r_done), 64'd1);
        check("t4_value", value, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t4_length", 64'(length), 64'd1);
        check("t4_next", 64'(next_addr), 64'd8);

        // reset pulled low while the 2nd byte is on the bus
        addr_in   = 5'd24;
        is_signed = 1'b0;
        is64      = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_trap", 64'(trap), 64'd0);
        check("mid_rst_value", value, 64'd0);
        check("mid_rst_length", 64'(length), 64'd0);
        check("mid_rst_next", 64'(next_addr), 64'd0);
        check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run(5'd24, 1'b0, 1'b0, 1'b0);
        check("t5_done", 64'(r_done), 64'd1);
        check("t5_value", value, 64'd150);
        check("t5_length", 64'(length), 64'd2);
        check("t5_next", 64'(next_addr), 64'd26);
        check("t5_latency", 64'(r_lat), 64'd3);

        // five continuation bytes in 32-bit mode -> overlong
        run(5'd8, 1'b0, 1'b0, 1'b0);
        check("t6_trap", 64'(r_trap), 64'd2);
        check("t6_no_done", 64'(r_done), 64'd0);
        check("t6_value", value, 64'd0);
        check("t6_latency", 64'(r_lat), 64'd6);
        check("t6_mem_addr_limit", 64'(mem_addr), 64'd12);

        // final 0x1F has bit 4 set -> invalid final-byte bits, held afterwards
        run(5'd14, 1'b0, 1'b0, 1'b0);
        check("t7_trap", 64'(r_trap), 64'd3);
        check("t7_no_done", 64'(r_done), 64'd0);
        check("t7_value", value, 64'd0);
        check("t7_latency", 64'(r_lat), 64'd6);
        repeat (2) @(negedge clk);
        check("t7_trap_held", 64'(trap), 64'd3);
        check("t7_busy_idle", 64'(busy), 64'd0);

        // final 0x0F -> 0xFFFFFFFF, trap cleared by the new start
        run(5'd19, 1'b0, 1'b0, 1'b0);
        check("t8_done", 64'(r_done), 64'd1);
        check("t8_trap", 64'(trap), 64'd0);
        check("t8_value", value, 64'h0000_0000_FFFF_FFFF);
        check("t8_length", 64'(length), 64'd5);
        check("t8_next", 64'(next_addr), 64'd24);
        check("t8_latency", 64'(r_lat), 64'd6);

        // 0x80 at the upper bound, 0x01 beyond it -> memory fault
        run(UB, 1'b0, 1'b0, 1'b0);
        check("t9_trap", 64'(r_trap), 64'd1);
        check("t9_no_done", 64'(r_done), 64'd0);
        check("t9_value", value, 64'd0);
        check("t9_latency", 64'(r_lat), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
